// File: rtl/byte_demux_1x4_if.sv
// Link-side bundle for the 1x4 byte demultiplexer: serial byte input, 4-lane group output
// with a valid/ready handshake, plus status.
interface byte_demux_1x4_if #(
  parameter int BW = 8
);
  logic [BW-1:0] Entrada;
  logic          validEntrada;
  logic          readySalida;
  logic [BW-1:0] Salida0;
  logic [BW-1:0] Salida1;
  logic [BW-1:0] Salida2;
  logic [BW-1:0] Salida3;
  logic          validSalida;
  logic          overflow;
  logic [1:0]    lane_ptr;

  // Producer/consumer side of the link
  modport master (
    output Entrada, validEntrada, readySalida,
    input  Salida0, Salida1, Salida2, Salida3, validSalida, overflow, lane_ptr
  );

  // Demultiplexer side
  modport slave (
    input  Entrada, validEntrada, readySalida,
    output Salida0, Salida1, Salida2, Salida3, validSalida, overflow, lane_ptr
  );
endinterface

// File: rtl/byte_demux_1x4.sv
// Splits a serial byte stream into round-robin 4-byte groups and presents each complete
// group on four lanes behind a single-slot valid/ready output register.
module byte_demux_1x4 #(
  parameter int BW = 8
) (
  input  logic             clk_4f,
  input  logic             reset,
  byte_demux_1x4_if.slave  bus
);

  typedef enum logic [1:0] {COLLECT0, COLLECT1, COLLECT2, COLLECT3} lane_e;
  typedef enum logic       {EMPTY, FULL} slot_e;

  lane_e         lane_q, lane_d;
  slot_e         slot_q, slot_d;
  logic [BW-1:0] asm0, asm1, asm2;
  logic [BW-1:0] sal0, sal1, sal2, sal3;
  logic          ovf_q;

  logic group_done, slot_free, load, drop;

  // The 4th byte bypasses the assembly registers and goes straight to Salida3.
  always_comb begin
    group_done = 1'b0;
    slot_free  = 1'b0;
    load       = 1'b0;
    drop       = 1'b0;
    lane_d     = lane_q;
    slot_d     = slot_q;

    group_done = bus.validEntrada && (lane_q == COLLECT3);
    slot_free  = (slot_q == EMPTY) || bus.readySalida;
    load       = group_done && slot_free;
    drop       = group_done && !slot_free;

    if (bus.validEntrada)
      lane_d = lane_e'(lane_q + 2'd1);

    case (slot_q)
      EMPTY:   if (load) slot_d = FULL;
      FULL:    if (!load && bus.readySalida) slot_d = EMPTY;
      default: slot_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      lane_q <= COLLECT0;
      slot_q <= EMPTY;
    end else begin
      lane_q <= lane_d;
      slot_q <= slot_d;
    end
  end

  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      asm0 <= '0;
      asm1 <= '0;
      asm2 <= '0;
    end else if (bus.validEntrada) begin
      case (lane_q)
        COLLECT0: asm0 <= bus.Entrada;
        COLLECT1: asm1 <= bus.Entrada;
        COLLECT2: asm2 <= bus.Entrada;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      sal0  <= '0;
      sal1  <= '0;
      sal2  <= '0;
      sal3  <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (load) begin
        sal0 <= asm0;
        sal1 <= asm1;
        sal2 <= asm2;
        sal3 <= bus.Entrada;
      end
      if (drop)
        ovf_q <= 1'b1;
    end
  end

  assign bus.Salida0     = sal0;
  assign bus.Salida1     = sal1;
  assign bus.Salida2     = sal2;
  assign bus.Salida3     = sal3;
  assign bus.validSalida = (slot_q == FULL);
  assign bus.overflow    = ovf_q;
  assign bus.lane_ptr    = lane_q;

endmodule

// File: tb/tb_byte_demux_1x4.sv
// Scoreboard bench for byte_demux_1x4: directed scenarios followed by randomized traffic,
// checked against a queue-based reference model of the byte grouping.
module tb_byte_demux_1x4;
  localparam int BW = 8;

  logic clk_4f = 1'b0;
  logic reset  = 1'b1;
  always #5 clk_4f = ~clk_4f;

  byte_demux_1x4_if #(.BW(BW)) bus ();
  byte_demux_1x4 #(.BW(BW)) dut (.clk_4f(clk_4f), .reset(reset), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  logic [4*BW-1:0] exp_q[$];
  logic [BW-1:0]   part[$];
  bit              exp_full = 1'b0;
  bit              exp_ovf  = 1'b0;
  bit              running  = 1'b0;

  function automatic void check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
    end
  endfunction

  // Reference: bytes accumulate in a list; every 4th byte closes a group that is either
  // queued for the consumer (slot free) or lost (slot busy -> sticky overflow).
  function automatic void model_edge(input bit v, input logic [BW-1:0] d, input bit r);
    bit loaded;
    bit free;
    loaded = 1'b0;
    free   = !exp_full || r;
    if (v) begin
      part.push_back(d);
      if (part.size() == 4) begin
        if (free) begin
          exp_q.push_back({part[0], part[1], part[2], part[3]});
          loaded = 1'b1;
        end else begin
          exp_ovf = 1'b1;
        end
        part.delete();
      end
    end
    if (loaded) exp_full = 1'b1;
    else if (r) exp_full = 1'b0;
  endfunction

  task automatic step(input bit v, input logic [BW-1:0] d, input bit r);
    bus.validEntrada = v;
    bus.Entrada      = d;
    bus.readySalida  = r;
    @(posedge clk_4f);
    model_edge(v, d, r);
    #1;
  endtask

  task automatic send_group(input logic [BW-1:0] b0, input bit r);
    for (int i = 0; i < 4; i++) step(1'b1, b0 + BW'(i), r);
  endtask

  task automatic do_reset();
    bus.validEntrada = 1'b0;
    #2 reset = 1'b1;
    exp_full = 1'b0;
    exp_ovf  = 1'b0;
    part.delete();
    exp_q.delete();
    #1;
    check("rst_validSalida", bus.validSalida, 0);
    check("rst_overflow", bus.overflow, 0);
    check("rst_lane_ptr", bus.lane_ptr, 0);
    @(posedge clk_4f);
    #1 reset = 1'b0;
  endtask

  // Monitor: checks status every cycle and pops the scoreboard on each consumption.
  always @(negedge clk_4f) begin
    logic [4*BW-1:0] g;
    if (running && !reset) begin
      check("validSalida", bus.validSalida, exp_full);
      check("overflow", bus.overflow, exp_ovf);
      check("lane_ptr", bus.lane_ptr, part.size());
      if (exp_full && bus.readySalida) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL scoreboard: consumption with no expected group at %0t", $time);
        end else begin
          g = exp_q.pop_front();
          check("Salida0..3", {bus.Salida0, bus.Salida1, bus.Salida2, bus.Salida3}, g);
        end
      end
    end
  end

  initial begin
    bus.validEntrada = 1'b0;
    bus.Entrada      = '0;
    bus.readySalida  = 1'b0;
    #12;
    check("rst_Salida", {bus.Salida0, bus.Salida1, bus.Salida2, bus.Salida3}, 0);
    check("rst_valid0", bus.validSalida, 0);
    check("rst_ovf0", bus.overflow, 0);
    check("rst_lane0", bus.lane_ptr, 0);
    @(posedge clk_4f);
    #1 reset = 1'b0;
    running = 1'b1;

    // Basic group with consumer ready
    send_group(8'hA0, 1'b1);
    repeat (3) step(1'b0, 8'h00, 1'b1);

    // Partial group held across idle cycles
    step(1'b1, 8'h11, 1'b1);
    step(1'b1, 8'h22, 1'b1);
    repeat (3) step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h33, 1'b1);
    step(1'b1, 8'h44, 1'b1);
    repeat (2) step(1'b0, 8'h00, 1'b1);

    // Backpressure and dropped group
    send_group(8'h01, 1'b0);
    send_group(8'h05, 1'b0);
    repeat (2) step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    send_group(8'h09, 1'b1);
    repeat (2) step(1'b0, 8'h00, 1'b1);

    // Sustained streaming
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, BW'(i), 1'b1);
    repeat (2) step(1'b0, 8'h00, 1'b1);

    // Consume and load on the same edge
    send_group(8'h10, 1'b0);
    step(1'b1, 8'h14, 1'b0);
    step(1'b1, 8'h15, 1'b0);
    step(1'b1, 8'h16, 1'b0);
    step(1'b1, 8'h17, 1'b1);
    repeat (2) step(1'b0, 8'h00, 1'b0);
    repeat (2) step(1'b0, 8'h00, 1'b1);

    // Reset mid-group
    step(1'b1, 8'hAA, 1'b1);
    step(1'b1, 8'hBB, 1'b1);
    do_reset();
    send_group(8'h01, 1'b1);
    repeat (2) step(1'b0, 8'h00, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      step($urandom_range(0, 3) != 0, BW'($urandom), 1'($urandom_range(0, 1)));
    end
    repeat (4) step(1'b0, 8'h00, 1'b1);

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d groups never consumed, required 0", exp_q.size());
    end
    running = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
